// File: rtl/key_debounce_if.sv
// Key debouncer signal bundle: raw key levels in, debounced levels and
// per-key edge pulses out. The master side drives the raw keys; the
// debouncer itself attaches through the slave modport.
interface key_debounce_if;
  logic [11:0] keys_raw;
  logic [11:0] keystroke;
  logic [11:0] key_press;
  logic [11:0] key_release;

  modport master (
    output keys_raw,
    input  keystroke,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  keys_raw,
    output keystroke,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debounce.sv
// 12-key debouncer.
// - Each raw key passes through a 2-flop synchroniser.
// - One shared prescaler produces a sample tick every TICK_DIV clk_raw cycles.
// - Each key keeps a STABLE_N-deep history of its tick samples. A new level
//   is accepted in the cycle after the history becomes uniform and disagrees
//   with the current debounced level.
// Optional feature macro KEY_EVENT_EN: when defined, key_press/key_release
// carry one-cycle pulses coincident with accepted rising/falling edges.
// When it is undefined, both ports stay at constant 0 and the edge
// registers are not built.
module key_debounce #(
  parameter int TICK_DIV = 50000,
  parameter int STABLE_N = 4
) (
  input logic     clk_raw,
  input logic     rst,
  key_debounce_if.slave bus
);

  localparam int NK = 12;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [NK-1:0]       r_sync1;
  logic [NK-1:0]       r_sync2;
  logic [CW-1:0]       r_cnt;
  logic                r_upd;
  logic [STABLE_N-1:0] r_hist [NK];
  logic [NK-1:0]       r_keystroke;

  logic                w_tick;
  logic [NK-1:0]       w_all1;
  logic [NK-1:0]       w_all0;
  logic [NK-1:0]       w_rise;
  logic [NK-1:0]       w_fall;

  assign w_tick = (r_cnt == TC);

  // Two-stage synchroniser for the asynchronous key inputs.
  always_ff @(posedge clk_raw or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.keys_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Shared prescaler; r_upd marks the cycle right after a history shift.
  always_ff @(posedge clk_raw or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_upd <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      r_upd <= w_tick;
    end
  end

  // Per-key sample history, shifted only on tick cycles.
  always_ff @(posedge clk_raw or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NK; i++) r_hist[i] <= '0;
    end else if (w_tick) begin
      for (int i = 0; i < NK; i++)
        r_hist[i] <= {r_hist[i][STABLE_N-2:0], r_sync2[i]};
    end
  end

  // Uniformity of each history word.
  always_comb begin
    w_all1 = '0;
    w_all0 = '0;
    for (int i = 0; i < NK; i++) begin
      w_all1[i] = &r_hist[i];
      w_all0[i] = ~|r_hist[i];
    end
  end

  // Rising/falling decisions are only taken right after a history update,
  // so a level change can never be accepted twice from the same history.
  assign w_rise = {NK{r_upd}} & w_all1 & ~r_keystroke;
  assign w_fall = {NK{r_upd}} & w_all0 &  r_keystroke;

  // Debounced level register.
  always_ff @(posedge clk_raw or posedge rst) begin
    if (rst) r_keystroke <= '0;
    else     r_keystroke <= (r_keystroke | w_rise) & ~w_fall;
  end

  assign bus.keystroke = r_keystroke;

`ifdef KEY_EVENT_EN
  logic [NK-1:0] r_press;
  logic [NK-1:0] r_release;

  // Edge pulses registered alongside keystroke so they line up with its change.
  always_ff @(posedge clk_raw or posedge rst) begin
    if (rst) begin
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_press   <= w_rise;
      r_release <= w_fall;
    end
  end

  assign bus.key_press   = r_press;
  assign bus.key_release = r_release;
`else
  assign bus.key_press   = '0;
  assign bus.key_release = '0;
`endif

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, giving clk_raw cycles per debounce sample tick (legal range >= 1).
REQ-002 SHALL have parameter STABLE_N, default 4, giving consecutive agreeing samples required to accept a level (legal range >= 2).
REQ-003 SHALL have port clk_raw  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port keys_raw  input  12  raw, unsynchronised, bouncing key levels (1 = pressed).
REQ-006 SHALL have port keystroke  output  12  debounced key levels, registered; directly drives core.keystroke.
REQ-007 SHALL have port key_press  output  12  one-cycle pulse per bit on accepted 0->1 transition.
REQ-008 SHALL have port key_release  output  12  one-cycle pulse per bit on accepted 1->0 transition.

Function
REQ-009 SHALL pass each keys_raw bit through a 2-flop synchroniser before any other use.
REQ-010 SHALL run one shared prescaler counting 0..TICK_DIV-1, asserting an internal tick in the cycle count == TICK_DIV-1 and then wrapping to 0; TICK_DIV=1 gives a tick every cycle.
REQ-011 SHALL keep, per key, a STABLE_N-bit history shift register that shifts in the synchronised bit only on tick cycles.
REQ-012 SHALL update keystroke[i] in the cycle after a history update when all STABLE_N history bits are equal and differ from keystroke[i]; otherwise keystroke[i] SHALL hold.
REQ-013 SHALL assert key_press[i] (key_release[i]) for exactly one cycle, coincident with the cycle keystroke[i] rises (falls).
REQ-014 SHALL accept an input step held steady with latency between (STABLE_N-1)*TICK_DIV+3 and STABLE_N*TICK_DIV+3 clk_raw cycles.
REQ-015 SHALL ignore any input pulse or bounce that does not persist across STABLE_N consecutive ticks; no output change, no pulse.
REQ-016 SHALL treat all 12 keys independently; several bits may change and pulse in the same cycle.
REQ-017 SHALL never assert key_press[i] and key_release[i] in the same cycle.

Reset
REQ-018 SHALL, while rst is high, asynchronously clear synchronisers, prescaler, all histories, keystroke, key_press and key_release to 0.
REQ-019 SHALL generate no pulse on rst deassertion; a key held throughout reset is accepted as a fresh press after normal debounce latency.
REQ-020 SHALL abandon any partially-debounced transition when reset is asserted mid-operation.

Configuration
REQ-021 SHALL use macro KEY_EVENT_EN to include edge-pulse logic.
REQ-022 SHALL, with KEY_EVENT_EN defined, behave per REQ-007, REQ-008, REQ-013.
REQ-023 SHALL, without KEY_EVENT_EN, keep key_press and key_release ports but drive them constant 0 and omit edge logic; keystroke behaviour unchanged.

Verification (bench parameters TICK_DIV=4, STABLE_N=3, KEY_EVENT_EN defined unless stated)
REQ-024 SHALL cover: reset then keys_raw=12'h000 for 100 cycles -> keystroke=12'h000, key_press=key_release=0 throughout.
REQ-025 SHALL cover: keys_raw steps 12'h000->12'h001 -> keystroke=12'h001 between 11 and 15 cycles later; key_press=12'h001 for exactly that one cycle.
REQ-026 SHALL cover: bit 1 toggles every 3 cycles for 40 cycles then holds 1 -> keystroke[1] stays 0 during bounce; exactly one key_press[1] pulse afterward.
REQ-027 SHALL cover: keys_raw 12'h0F0 applied in one cycle -> keystroke bits 7:4 rise in the same cycle, key_press=12'h0F0 for one cycle; then 12'h000 -> key_release=12'h0F0 for one cycle.
REQ-028 SHALL cover: rst pulsed while keystroke=12'h008 and bit 2 mid-debounce -> all outputs 0 during reset, no pulse on release; bit 3 still held -> key_press=12'h008 within 15 cycles after rst falls.
REQ-029 SHALL cover: KEY_EVENT_EN undefined, rerun REQ-025 and REQ-027 stimulus -> keystroke identical, key_press and key_release constantly 0.
